multi_edge_detector: RTL and testbench
======================================

# multi_edge_detector

Parametrised multi-channel edge detector that generalises the single-channel rising-edge pulse generator. Each channel debounces its level input, detects rising, falling or both edges under a per-channel run-time mode, and emits an output pulse of configurable length plus a sticky event flag. It sits between raw level signals (buttons, status lines, handshake levels) and control logic that needs one-shot events.

## Interface
- CH, 4, number of independent channels (>=1)
- DEBOUNCE, 1, consecutive samples a new level must hold before it is accepted (>=1; 1 = no filtering)
- PULSE_LEN, 1, output pulse length in cycles (>=1)

- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk
- levelin  input  CH  raw level per channel
- mode  input  2*CH  per-channel mode, bits [2i+1:2i]: 00 OFF, 01 RISE, 10 FALL, 11 BOTH
- clr  input  CH  per-channel sticky-flag clear, one-cycle strobe
- outpulse  output  CH  per-channel pulse, high for PULSE_LEN cycles per qualifying edge
- event_flag  output  CH  per-channel sticky flag, set by a qualifying edge
- level  output  CH  per-channel debounced level

## Operation
- Reset (rst low at a clk edge): filtered level, debounce counter, pulse counter, event_flag, and any synchroniser flops go to 0. Outputs outpulse, event_flag and level are 0 in the cycle after reset.
- s = sampled level: levelin directly, or the synchroniser output when the synchroniser is compiled in.
- Debounce per channel: if s == level, cnt <= 0. If s != level and cnt == DEBOUNCE-1, level <= s, cnt <= 0, and a raw edge occurs (rising if s == 1, else falling). Otherwise cnt <= cnt+1. A single sample back at the old level restarts the count.
- Qualification: a raw edge qualifies if mode is RISE and the edge is rising, FALL and falling, or BOTH. OFF never qualifies. Filtering and level continue in every mode.
- mode is sampled on the same clk edge as the raw edge, so a mode change applies from that edge.
- Pulse: a qualifying edge loads pcnt <= PULSE_LEN; otherwise, if pcnt != 0, pcnt <= pcnt-1. outpulse = (pcnt != 0).
- A qualifying edge during an active pulse retriggers it: the counter reloads and the pulse is extended, with no gap.
- Sticky flag: a qualifying edge sets event_flag; clr clears it. If set and clear occur in the same cycle, set wins.
- Because level resets to 0, an input held high through reset produces a rising edge after DEBOUNCE samples.
- Channels are fully independent; simultaneous edges on several channels are each handled.
- Counter widths: cnt is $clog2(DEBOUNCE+1) bits and pcnt is $clog2(PULSE_LEN+1) bits, both unsigned, with no wrap-around.

## Timing
- Without the synchroniser: levelin changes and holds; it is first sampled at edge t0. The raw edge registers at edge t0+DEBOUNCE-1. outpulse and event_flag go high in the following cycle. With DEBOUNCE=1 this gives one-cycle latency.
- outpulse stays high for exactly PULSE_LEN cycles unless retriggered.
- level changes in the same cycle that outpulse rises.
- The minimum spacing of distinguishable edges on one channel is DEBOUNCE cycles.

## Configuration
- EDGEDET_SYNC_EN defined: a 2-flop synchroniser per channel (reset to 0) precedes the debounce stage. Every latency above grows by 2 cycles, and levelin may be asynchronous.
- EDGEDET_SYNC_EN undefined: levelin feeds the debounce stage directly and must be synchronous to clk.

## Structure
- Package edgedet_pkg holds:
  - typedef enum logic [1:0] {MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH} edge_mode_t
  - helper constants for the mode bit slicing
- Sub-module edge_chan covers one channel (optional synchroniser, debounce, qualification, pulse counter, sticky flag). The top level generates CH instances of it.

## Test plan
- CH=4, DEBOUNCE=1, PULSE_LEN=1, mode=RISE on all channels: levelin[0] goes 0->1 at t0 -> outpulse[0] high for exactly 1 cycle after t0, event_flag[0]=1; the 1->0 transition produces no pulse.
- mode[3:2]=BOTH, PULSE_LEN=3: levelin[1] rises, then falls 10 cycles later -> two 3-cycle pulses; level[1] tracks the input delayed by one cycle.
- DEBOUNCE=4: levelin[2] shows a 3-cycle high glitch -> no pulse and level[2] stays 0. The input then holds high for 4 cycles -> pulse one cycle after the 4th sample.
- PULSE_LEN=4, mode=BOTH, DEBOUNCE=1: edges 2 cycles apart -> outpulse continuously high for 6 cycles (retrigger).
- A qualifying edge and clr[0] asserted in the same cycle -> event_flag[0] stays 1; clr[0] alone next cycle -> 0. mode=OFF -> no pulse or flag, but level still updates.
- Hold levelin=all ones across reset; drop rst low mid-pulse -> all outputs 0 the next cycle. After release -> rising pulses on all RISE/BOTH channels. With EDGEDET_SYNC_EN, every latency check passes with +2 cycles.

Source files
------------

// File: rtl/edgedet_pkg.sv
// -----------------------------------------------------------------------------
// edgedet_pkg
// Shared types and helpers for the multi-channel edge detector.
//   edge_mode_t    : per-channel edge mode (OFF / RISE / FALL / BOTH)
//   MODE_W         : bits of mode per channel in the packed mode bus
//   mode_lsb()     : LSB position of channel ch inside the packed mode bus
//   edge_qualifies : whether a raw edge of the given direction counts under a mode
// -----------------------------------------------------------------------------
package edgedet_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } edge_mode_t;

    // Bit offset of a channel's mode field in the packed {chN..ch0} mode bus.
    function automatic int unsigned mode_lsb(input int unsigned ch);
        return ch * MODE_W;
    endfunction

    // rising = 1 for a 0->1 edge, 0 for a 1->0 edge.
    function automatic logic edge_qualifies(input edge_mode_t m, input logic rising);
        logic q;
        q = 1'b0;
        case (m)
            MODE_RISE: q = rising;
            MODE_FALL: q = !rising;
            MODE_BOTH: q = 1'b1;
            default:   q = 1'b0;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/multi_edge_detector_if.sv
// -----------------------------------------------------------------------------
// multi_edge_detector_if
// Bundles the per-channel signals of the edge detector.
//   levelin    : raw level per channel                    (master -> slave)
//   mode       : packed 2-bit mode per channel            (master -> slave)
//   clr        : sticky-flag clear strobe per channel     (master -> slave)
//   outpulse   : pulse per qualifying edge                (slave -> master)
//   event_flag : sticky event flag                        (slave -> master)
//   level      : debounced level                          (slave -> master)
// -----------------------------------------------------------------------------
interface multi_edge_detector_if
    import edgedet_pkg::*;
#(
    parameter int unsigned CH = 4
);

    logic [CH-1:0]        levelin;
    logic [MODE_W*CH-1:0] mode;
    logic [CH-1:0]        clr;
    logic [CH-1:0]        outpulse;
    logic [CH-1:0]        event_flag;
    logic [CH-1:0]        level;

    modport master (
        output levelin,
        output mode,
        output clr,
        input  outpulse,
        input  event_flag,
        input  level
    );

    modport slave (
        input  levelin,
        input  mode,
        input  clr,
        output outpulse,
        output event_flag,
        output level
    );

endinterface

// File: rtl/multi_edge_detector_chan.sv
// -----------------------------------------------------------------------------
// edge_chan
// One channel of the edge detector: optional 2-flop synchroniser, debounce
// filter, edge qualification by mode, retriggerable pulse counter and sticky
// event flag.
// Macro EDGEDET_SYNC_EN: when defined, levelin passes through a 2-flop
// synchroniser (reset to 0) before the debounce stage; all latencies grow by 2.
// Ports:
//   clk, rst   : clock, synchronous active-low reset
//   levelin    : raw level
//   mode       : edge mode for this channel
//   clr        : sticky-flag clear strobe
//   outpulse   : registered pulse, PULSE_LEN cycles per qualifying edge
//   event_flag : registered sticky flag
//   level      : registered debounced level
// -----------------------------------------------------------------------------
module edge_chan
    import edgedet_pkg::*;
#(
    parameter int unsigned DEBOUNCE  = 1,
    parameter int unsigned PULSE_LEN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       levelin,
    input  edge_mode_t mode,
    input  logic       clr,
    output logic       outpulse,
    output logic       event_flag,
    output logic       level
);

    localparam int unsigned CNT_W  = $clog2(DEBOUNCE + 1);
    localparam int unsigned PCNT_W = $clog2(PULSE_LEN + 1);

    logic              sample_c;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic              level_q, level_d;
    logic              flag_q,  flag_d;
    logic              pulse_q;
    logic              raw_edge_c;
    logic              qual_c;

`ifdef EDGEDET_SYNC_EN
    // Two-stage synchroniser; levelin may be asynchronous to clk.
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], levelin};
        end
    end

    assign sample_c = sync_q[1];
`else
    assign sample_c = levelin;
`endif

    // Debounce: a new level is accepted after DEBOUNCE consecutive differing samples.
    always_comb begin
        cnt_d      = cnt_q;
        level_d    = level_q;
        raw_edge_c = 1'b0;
        if (sample_c == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
            level_d    = sample_c;
            cnt_d      = '0;
            raw_edge_c = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // The new level value gives the edge direction.
    assign qual_c = raw_edge_c && edge_qualifies(mode, sample_c);

    // Pulse counter: qualifying edge (re)loads, otherwise count down to zero.
    always_comb begin
        pcnt_d = pcnt_q;
        if (qual_c) begin
            pcnt_d = PCNT_W'(PULSE_LEN);
        end else if (pcnt_q != '0) begin
            pcnt_d = pcnt_q - PCNT_W'(1);
        end
    end

    // Sticky flag: set has priority over clear.
    always_comb begin
        flag_d = flag_q;
        if (qual_c) begin
            flag_d = 1'b1;
        end else if (clr) begin
            flag_d = 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q   <= '0;
            pcnt_q  <= '0;
            level_q <= 1'b0;
            flag_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            level_q <= level_d;
            flag_q  <= flag_d;
            pulse_q <= (pcnt_d != '0);
        end
    end

    assign outpulse   = pulse_q;
    assign event_flag = flag_q;
    assign level      = level_q;

endmodule

// File: rtl/multi_edge_detector.sv
// -----------------------------------------------------------------------------
// multi_edge_detector
// CH independent edge-detector channels with debounce, per-channel mode,
// retriggerable output pulse and sticky event flag.
// Macro EDGEDET_SYNC_EN: when defined, each channel adds a 2-flop input
// synchroniser so levelin may be asynchronous.
// Ports:
//   clk : clock
//   rst : synchronous active-low reset
//   bus : multi_edge_detector_if.slave (levelin, mode, clr in;
//         outpulse, event_flag, level out)
// Parameters: CH channels, DEBOUNCE samples to accept a level,
//             PULSE_LEN pulse length in cycles.
// -----------------------------------------------------------------------------
module multi_edge_detector
    import edgedet_pkg::*;
#(
    parameter int unsigned CH        = 4,
    parameter int unsigned DEBOUNCE  = 1,
    parameter int unsigned PULSE_LEN = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    multi_edge_detector_if.slave        bus
);

    logic [CH-1:0] pulse_v;
    logic [CH-1:0] flag_v;
    logic [CH-1:0] level_v;

    // One channel instance per bit; channels share nothing but clock and reset.
    for (genvar i = 0; i < int'(CH); i++) begin : g_chan
        edge_mode_t chan_mode_c;

        assign chan_mode_c = edge_mode_t'(bus.mode[mode_lsb(i) +: MODE_W]);

        edge_chan #(
            .DEBOUNCE  (DEBOUNCE),
            .PULSE_LEN (PULSE_LEN)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .levelin    (bus.levelin[i]),
            .mode       (chan_mode_c),
            .clr        (bus.clr[i]),
            .outpulse   (pulse_v[i]),
            .event_flag (flag_v[i]),
            .level      (level_v[i])
        );
    end

    assign bus.outpulse   = pulse_v;
    assign bus.event_flag = flag_v;
    assign bus.level      = level_v;

endmodule

// File: tb/tb_multi_edge_detector.sv
// -----------------------------------------------------------------------------
// tb_multi_edge_detector
// Four detector instances with different DEBOUNCE/PULSE_LEN share one stimulus
// stream. A behavioural model (sample history window, time of last qualifying
// edge) predicts every output each cycle; literal expectations pin key points.
// -----------------------------------------------------------------------------
module tb_multi_edge_detector;

    localparam int unsigned CH = 4;
    localparam int NI = 4;
`ifdef EDGEDET_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int DBS [NI] = '{1, 1, 4, 1};
    localparam int PLS [NI] = '{1, 3, 3, 4};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [CH-1:0]   levelin = '0;
    logic [2*CH-1:0] mode    = '0;
    logic [CH-1:0]   clr     = '0;

    multi_edge_detector_if #(.CH(CH)) if0 ();
    multi_edge_detector_if #(.CH(CH)) if1 ();
    multi_edge_detector_if #(.CH(CH)) if2 ();
    multi_edge_detector_if #(.CH(CH)) if3 ();

    assign if0.levelin = levelin; assign if0.mode = mode; assign if0.clr = clr;
    assign if1.levelin = levelin; assign if1.mode = mode; assign if1.clr = clr;
    assign if2.levelin = levelin; assign if2.mode = mode; assign if2.clr = clr;
    assign if3.levelin = levelin; assign if3.mode = mode; assign if3.clr = clr;

    logic [CH-1:0] dut_pulse [NI];
    logic [CH-1:0] dut_flag  [NI];
    logic [CH-1:0] dut_level [NI];

    assign dut_pulse[0] = if0.outpulse; assign dut_flag[0] = if0.event_flag; assign dut_level[0] = if0.level;
    assign dut_pulse[1] = if1.outpulse; assign dut_flag[1] = if1.event_flag; assign dut_level[1] = if1.level;
    assign dut_pulse[2] = if2.outpulse; assign dut_flag[2] = if2.event_flag; assign dut_level[2] = if2.level;
    assign dut_pulse[3] = if3.outpulse; assign dut_flag[3] = if3.event_flag; assign dut_level[3] = if3.level;

    multi_edge_detector #(.CH(CH), .DEBOUNCE(1), .PULSE_LEN(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    multi_edge_detector #(.CH(CH), .DEBOUNCE(1), .PULSE_LEN(3)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    multi_edge_detector #(.CH(CH), .DEBOUNCE(4), .PULSE_LEN(3)) dut2 (.clk(clk), .rst(rst), .bus(if2));
    multi_edge_detector #(.CH(CH), .DEBOUNCE(1), .PULSE_LEN(4)) dut3 (.clk(clk), .rst(rst), .bus(if3));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int k, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d t=%0t actual=%b required=%b", name, k, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int cyc = 0;
    bit mlvl  [NI][CH];
    bit mflag [NI][CH];
    bit msy1  [NI][CH];
    bit msy2  [NI][CH];
    int mlastq[NI][CH];
    bit mhist [NI][CH][$];

    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < NI; k++) begin
            for (int c = 0; c < int'(CH); c++) begin
                if (!rst) begin
                    mlvl[k][c]   = 1'b0;
                    mflag[k][c]  = 1'b0;
                    msy1[k][c]   = 1'b0;
                    msy2[k][c]   = 1'b0;
                    mlastq[k][c] = -1000;
                    mhist[k][c].delete();
                end else begin
                    bit s;
                    bit accept;
                    bit qual;
                    logic [1:0] m;
                    s = (LAT != 0) ? msy2[k][c] : levelin[c];
                    msy2[k][c] = msy1[k][c];
                    msy1[k][c] = levelin[c];
                    // Level accepted when the last DEBOUNCE samples all disagree with it.
                    mhist[k][c].push_back(s);
                    if (mhist[k][c].size() > DBS[k]) void'(mhist[k][c].pop_front());
                    accept = (mhist[k][c].size() == DBS[k]);
                    for (int j = 0; j < mhist[k][c].size(); j++)
                        if (mhist[k][c][j] == mlvl[k][c]) accept = 1'b0;
                    qual = 1'b0;
                    if (accept) begin
                        mlvl[k][c] = s;
                        m = mode[2*c +: 2];
                        qual = (m == 2'b11) || (m == 2'b01 && s) || (m == 2'b10 && !s);
                    end
                    if (qual) begin
                        mflag[k][c]  = 1'b1;
                        mlastq[k][c] = cyc;
                    end else if (clr[c]) begin
                        mflag[k][c] = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit checking = 1'b0;

    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < NI; k++) begin
                logic [CH-1:0] ep, ef, el;
                for (int c = 0; c < int'(CH); c++) begin
                    ep[c] = (cyc - mlastq[k][c]) < PLS[k];
                    ef[c] = mflag[k][c];
                    el[c] = mlvl[k][c];
                end
                chk("model_outpulse", k, dut_pulse[k], ep);
                chk("model_event_flag", k, dut_flag[k], ef);
                chk("model_level", k, dut_level[k], el);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int n;
        mode = 8'h55;
        step(3);
        checking = 1'b1;
        chk("reset_pulse", 0, dut_pulse[0], 4'b0000);
        chk("reset_flag", 0, dut_flag[0], 4'b0000);
        chk("reset_level", 0, dut_level[0], 4'b0000);
        rst = 1'b1;
        step(2);

        // Rising edge ch0, PULSE_LEN=1, then falling edge ignored in RISE mode.
        levelin[0] = 1'b1;
        step(1 + LAT);
        chk("rise_pulse", 0, dut_pulse[0], 4'b0001);
        chk("rise_flag", 0, dut_flag[0], 4'b0001);
        chk("rise_level", 0, dut_level[0], 4'b0001);
        step(1);
        chk("rise_pulse_len1", 0, dut_pulse[0], 4'b0000);
        levelin[0] = 1'b0;
        step(3 + LAT);
        chk("fall_no_pulse", 0, dut_pulse[0], 4'b0000);
        chk("fall_level", 0, dut_level[0], 4'b0000);

        // BOTH mode on ch1: rise then fall 10 cycles later, PULSE_LEN=3.
        mode[3:2] = 2'b11;
        levelin[1] = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) levelin[1] = 1'b0;
            step(1);
            n += int'(dut_pulse[1][1]);
        end
        chk("both_pulse_cycles", 1, CH'(n), CH'(6));

        // 3-cycle glitch on ch2 must not pass DEBOUNCE=4; a 4-sample hold must.
        levelin[2] = 1'b1;
        step(3);
        levelin[2] = 1'b0;
        step(3 + LAT);
        chk("glitch_level", 2, dut_level[2], 4'b0000);
        chk("glitch_pulse", 2, dut_pulse[2], 4'b0000);
        levelin[2] = 1'b1;
        step(3 + LAT);
        chk("db_before_4th", 2, dut_pulse[2], 4'b0000);
        step(1);
        chk("db_after_4th", 2, dut_pulse[2], 4'b0100);
        chk("db_level", 2, dut_level[2], 4'b0100);

        // Retrigger on ch3: edges 2 cycles apart, PULSE_LEN=4 -> 6 high cycles.
        mode[7:6] = 2'b11;
        levelin[3] = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) levelin[3] = 1'b0;
            step(1);
            n += int'(dut_pulse[3][3]);
        end
        chk("retrigger_cycles", 3, CH'(n), CH'(6));

        // Clear alone, then set+clear same cycle (set wins), then clear alone.
        clr[0] = 1'b1;
        step(1);
        clr[0] = 1'b0;
        chk("clr_alone", 0, dut_flag[0], 4'b1110);
        levelin[0] = 1'b1;
        step(LAT);
        clr[0] = 1'b1;
        step(1);
        chk("set_beats_clr", 0, dut_flag[0], 4'b1111);
        step(1);
        clr[0] = 1'b0;
        chk("clr_after_set", 0, dut_flag[0], 4'b1110);

        // OFF mode on ch1: level follows, no pulse or flag change.
        mode[3:2] = 2'b00;
        levelin[1] = 1'b1;
        step(1 + LAT);
        chk("off_level", 0, dut_level[0], 4'b0111);
        chk("off_pulse", 0, dut_pulse[0], 4'b0000);
        chk("off_flag", 0, dut_flag[0], 4'b1110);
        levelin[1] = 1'b0;
        step(1 + LAT);

        // Reset mid-pulse with all inputs high, then rising edges after release.
        mode = 8'hFF;
        levelin = 4'hF;
        step(1 + LAT);
        chk("pre_reset_pulse", 3, dut_pulse[3], 4'b1010);
        rst = 1'b0;
        step(1);
        chk("mid_reset_pulse", 3, dut_pulse[3], 4'b0000);
        chk("mid_reset_flag", 3, dut_flag[3], 4'b0000);
        chk("mid_reset_level", 3, dut_level[3], 4'b0000);
        step(2);
        rst = 1'b1;
        step(1 + LAT);
        chk("post_reset_pulse", 0, dut_pulse[0], 4'b1111);
        chk("post_reset_level", 0, dut_level[0], 4'b1111);
        step(8);
        chk("post_reset_flag", 2, dut_flag[2], 4'b1111);
        chk("post_reset_level_db", 2, dut_level[2], 4'b1111);

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t actual=running required=finished", $time);
        $fatal(1);
    end

endmodule
